lsu_bus_if: RTL

- Parametrised load/store unit that will replace the current single-cycle, same-cycle memory access in the core.
- Accepts one memory request from the execute stage through a valid/ready handshake.
- Issues one aligned bus transaction with byte strobes, then returns a size-adjusted, sign- or zero-extended result with an error code.
- Supports XLEN 32/64, detects misalignment, bounds bus latency with a timeout, and tolerates back-pressure on both sides.

---
 rtl/lsu_bus_if_pkg.sv | 24 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_bus_if.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lsu_bus_if_pkg.sv
// Shared types and constants for the load/store bus interface.
package lsu_bus_if_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  // FSM encoding kept as plain constants so older tools can share it.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: alignment check, store lane shifting and load extract/extend.
module lsu_align
  import lsu_bus_if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [1:0]                size,
  input  logic                      sext,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  output logic                      misalign,
  output logic [XLEN/8-1:0]         wstrb,
  output logic [XLEN-1:0]           wdata_lane,
  output logic [XLEN-1:0]           rdata_ext
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] mask;
  logic [7:0]      nmask;
  logic            sign;

  assign sh = rdata >> {off, 3'b000};

  // Per-size byte mask and sign bit of the right-justified load data.
  always_comb begin
    nmask = 8'hFF;
    mask  = '1;
    sign  = sh[XLEN-1];
    case (size)
      SZ_B: begin nmask = 8'h01; mask = XLEN'(8'hFF);         sign = sh[7];  end
      SZ_H: begin nmask = 8'h03; mask = XLEN'(16'hFFFF);      sign = sh[15]; end
      SZ_W: begin nmask = 8'h0F; mask = XLEN'(32'hFFFF_FFFF); sign = sh[31]; end
      default: begin nmask = 8'hFF; mask = '1; sign = sh[XLEN-1]; end
    endcase
  end

  // Dword on a 32-bit core is illegal; otherwise offset must be a multiple of the size.
  assign misalign = ((size == SZ_D) && (XLEN == 32)) ||
                    ((off & OW'((1 << size) - 1)) != '0);

  assign wstrb      = BW'(nmask) << off;
  assign wdata_lane = wdata << {off, 3'b000};
  // A full-width mask leaves ~mask empty, so word-on-32 and dword ignore sext.
  assign rdata_ext  = (sh & mask) | ((sext && sign) ? ~mask : '0);

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit: one core request becomes one aligned bus transaction and one response.
module lsu_bus_if
  import lsu_bus_if_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [AW-1:0]     bus_req_addr,
  output logic              bus_req_wen,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_wstrb,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_resp_rdata,
  input  logic              bus_resp_err
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]      state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [1:0]      size_q;
  logic            sext_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      err_q;

  logic            in_idle, in_req, in_wait, in_resp;
  logic            accept, limit, resp_take, timeout_fire;
  logic [OW-1:0]   al_off;
  logic [1:0]      al_size;
  logic            misalign;
  logic [BW-1:0]   lane_strb;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;

  assign in_idle = (state_q == ST_IDLE);
  assign in_req  = (state_q == ST_REQ);
  assign in_wait = (state_q == ST_WAIT);
  assign in_resp = (state_q == ST_RESP);

  assign accept    = in_idle && req_valid;
  assign resp_take = in_wait && bus_resp_valid;
  // cnt_q counts cycles already spent in REQ/WAIT, so this cycle is number cnt_q+1.
  assign limit        = (cnt_q == CW'(TIMEOUT - 1));
  assign timeout_fire = limit && ((in_req && !bus_req_ready) || (in_wait && !bus_resp_valid));

  // The alignment check looks at the incoming request; lane logic uses the latched one.
  assign al_off  = in_idle ? req_addr[OW-1:0] : addr_q[OW-1:0];
  assign al_size = in_idle ? req_size : size_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .off        (al_off),
    .size       (al_size),
    .sext       (sext_q),
    .wdata      (wdata_q),
    .rdata      (bus_resp_rdata),
    .misalign   (misalign),
    .wstrb      (lane_strb),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_data)
  );

  // Transaction FSM and timeout counter; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= misalign ? ST_RESP : ST_REQ;
            cnt_q   <= '0;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus_req_ready)  state_q <= ST_WAIT;
          else if (limit)     state_q <= ST_RESP;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus_resp_valid) state_q <= ST_RESP;
          else if (limit)     state_q <= ST_RESP;
        end
        default: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Request latch and response capture; outputs are gated by state, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wen_q   <= req_wen;
      size_q  <= req_size;
      sext_q  <= req_sext;
      wdata_q <= req_wdata;
      if (misalign) begin
        rdata_q <= '0;
        err_q   <= ERR_MISALIGN;
      end
    end
    if (resp_take) begin
      rdata_q <= (wen_q || bus_resp_err) ? '0 : load_data;
      err_q   <= bus_resp_err ? ERR_BUS : ERR_OK;
    end else if (timeout_fire) begin
      rdata_q <= '0;
      err_q   <= ERR_TIMEOUT;
    end
  end

  assign req_ready     = in_idle;
  assign resp_valid    = in_resp;
  assign resp_rdata    = in_resp ? rdata_q : '0;
  assign resp_err      = in_resp ? err_q : ERR_OK;
  assign bus_req_valid = in_req;
  assign bus_req_addr  = in_req ? (addr_q & ~AW'(BW - 1)) : '0;
  assign bus_req_wen   = in_req && wen_q;
  assign bus_req_wdata = (in_req && wen_q) ? lane_wdata : '0;
  assign bus_req_wstrb = in_req ? (wen_q ? lane_strb : '1) : '0;

endmodule
